// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, legal opcode bound and the
// arbiter state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLL    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_OP_MAX = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant. The search starts one past the last winner;
// the pointer moves only when the caller reports a completed handshake.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         enable,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] r_last;
  logic [IW-1:0] w_win_idx;
  logic          w_found;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return s[IW-1:0];
  endfunction

  always_comb begin
    grant     = '0;
    w_found   = 1'b0;
    w_win_idx = r_last;
    for (int k = 1; k <= N; k++) begin
      if (!w_found && req[wrap_add(r_last, k)]) begin
        w_found   = 1'b1;
        w_win_idx = wrap_add(r_last, k);
      end
    end
    if (enable && w_found) grant[w_win_idx] = 1'b1;
  end

  // Pointer resets to the highest index so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= IW'(N - 1);
    end else if (advance && w_found) begin
      r_last <= w_win_idx;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: round-robin
// accept, registered operands into the ALU, back-pressured response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*4-1:0] req_op,
  output logic [31:0]          alu_input_a,
  output logic [31:0]          alu_input_b,
  output logic [3:0]           alu_op_out,
  input  logic [31:0]          alu_result,
  input  logic                 alu_zero,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_err
);

  logic [31:0] w_a  [NUM_REQ];
  logic [31:0] w_b  [NUM_REQ];
  logic [3:0]  w_op [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_a[gi]  = req_a[gi*32 +: 32];
      assign w_b[gi]  = req_b[gi*32 +: 32];
      assign w_op[gi] = req_op[gi*4 +: 4];
    end
  endgenerate

  state_t              r_state;
  state_t              w_state_next;
  logic                w_accept;
  logic                w_hs;
  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_sel_id;
  logic [31:0]         w_sel_a;
  logic [31:0]         w_sel_b;
  logic [3:0]          w_sel_op;

  logic [31:0]         r_a;
  logic [31:0]         r_b;
  logic [3:0]          r_op;
  logic [ID_W-1:0]     r_id;
  logic [31:0]         r_result;
  logic                r_zero;
  logic                r_err;

  // rst_n gates the window so req_ready reads 0 while reset is held.
  assign w_accept = rst_n & ((r_state == IDLE) | ((r_state == RESP) & rsp_ready));

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .enable  (w_accept),
    .advance (w_hs),
    .grant   (w_grant)
  );

  assign req_ready = w_grant;
  assign w_hs      = |(req_valid & w_grant);

  always_comb begin
    w_sel_id = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_id = ID_W'(i);
        w_sel_a  = w_a[i];
        w_sel_b  = w_b[i];
        w_sel_op = w_op[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    rsp_valid    = 1'b0;
    case (r_state)
      IDLE: if (w_hs) w_state_next = EXEC;
      EXEC: w_state_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_next = w_hs ? EXEC : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operands only change on a handshake, so the ALU sees stable inputs
  // in IDLE and RESP and the response fields are stable until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_id     <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_hs) begin
        r_a  <= w_sel_a;
        r_b  <= w_sel_b;
        r_op <= w_sel_op;
        r_id <= w_sel_id;
      end
      if (r_state == EXEC) begin
        r_result <= alu_result;
        r_zero   <= alu_zero;
        r_err    <= (r_op > ALU_OP_MAX);
      end
    end
  end

  assign alu_input_a = r_a;
  assign alu_input_b = r_b;
  assign alu_op_out  = r_op;
  assign rsp_id      = r_id;
  assign rsp_result  = r_result;
  assign rsp_zero    = r_zero;
  assign rsp_err     = r_err;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between `NUM_REQ` requesters (e.g. the integer issue port and the address-generation/branch unit). It selects requests round-robin over a valid/ready handshake, registers the chosen operands into the ALU, and captures the result. It returns the result with the requester ID over a back-pressured response channel. It sits between the requesters and the ALU instance and owns the ALU's `input_a`/`input_b`/`alu_op` inputs.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 2–4.
- `ID_W`, default 2: width of the requester ID, must satisfy `2**ID_W >= NUM_REQ`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester grant/accept; one-hot or zero.
- `req_a`  in  NUM_REQ*32  packed operand A; slice i belongs to requester i.
- `req_b`  in  NUM_REQ*32  packed operand B.
- `req_op`  in  NUM_REQ*4  packed ALU opcode.
- `alu_input_a`  out  32  to ALU `input_a`.
- `alu_input_b`  out  32  to ALU `input_b`.
- `alu_op_out`  out  4  to ALU `alu_op`.
- `alu_result`  in  32  from ALU.
- `alu_zero`  in  1  from ALU `zero`.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  ID_W  index of the requester being answered.
- `rsp_result`  out  32  captured ALU result.
- `rsp_zero`  out  1  captured zero flag.
- `rsp_err`  out  1  the opcode was outside 0x0–0x6.

## Operation
- States: IDLE, EXEC, RESP.
- **Accept window.** `accept = (state==IDLE) | (state==RESP & rsp_ready)`. While `accept` is high, `req_ready` is asserted only to the round-robin winner among the asserted `req_valid` bits. Otherwise `req_ready = 0`.
- **Round-robin order.** Search starts at `(last_grant+1) mod NUM_REQ` and wraps. `last_grant` updates only on a handshake, i.e. `req_valid[g] & req_ready[g]`.
- **Handshake.** On the handshake edge, latch `req_a`/`req_b`/`req_op` slice g and the ID g, then go to EXEC.
- **EXEC.**
  - `alu_input_a`, `alu_input_b` and `alu_op_out` are driven from the latched registers.
  - At the next edge, capture `alu_result` and `alu_zero` into `rsp_result` and `rsp_zero`.
  - Set `rsp_err` to `(op > 4'b0110)`. The ALU still produces 0 for such opcodes and that result is forwarded.
  - Go to RESP.
- **RESP.**
  - `rsp_valid = 1`. All `rsp_*` outputs stay stable until `rsp_ready`.
  - If `rsp_ready` is high and a request is accepted the same cycle, go to EXEC.
  - If `rsp_ready` is high and no request is accepted, go to IDLE.
  - If `rsp_ready` is low, stay in RESP.
- **Idle ALU inputs.** In IDLE and RESP, the ALU inputs keep their last latched values; they are not re-driven from requesters.
- **Request validity.** A requester must hold valid and payload stable until ready. The arbiter does not check this.
- **Reset.** Asynchronous assertion in any state:
  - The state returns to IDLE and any in-flight transaction is dropped with no response.
  - `last_grant` is set to NUM_REQ-1, so requester 0 wins first.
  - All outputs and registers are set to 0.

## Timing
- **Reset values.** `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_result=0`, `rsp_zero=0`, `rsp_err=0`, `alu_input_a=0`, `alu_input_b=0`, `alu_op_out=0`.
- **Latency.** A handshake at edge T produces EXEC in cycle T..T+1, and `rsp_valid` rises right after edge T+1. Handshake to response is 2 edges.
- **Throughput.** One operation per 2 cycles with `rsp_ready` held high, or one per 3 cycles when the consumer returns through IDLE.
- **Combinational path.** `req_ready` depends combinationally on `req_valid`, `state` and `rsp_ready`. There is no path from `req_ready` back to any input.
- **ALU path.** The ALU is one combinational path from register to register. There is no combinational path from a requester's `req_a` to the ALU.

## Structure
- **Shared package `alu_pkg`:**
  - opcode constants ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4, ALU_SLL=5, ALU_SRL=6
  - `ALU_OP_MAX=6`
  - the state enum `{IDLE, EXEC, RESP}`
- **Sub-module `rr_arbiter`:** a parameterised round-robin grant with inputs `req`, `enable`, `advance` and output `grant` (one-hot), holding the `last_grant` pointer. The `alu_arbiter` top holds the FSM, the operand/response registers and the packing/unpacking.

## Test plan
- **Single request.** Req0 sends `a=5`, `b=3`, `op=1`, `rsp_ready=1` → `rsp_valid` 2 edges after the handshake, with `rsp_result=2`, `rsp_zero=0`, `rsp_id=0`, `rsp_err=0`.
- **Round-robin.** Req0 and req1 hold valid continuously (ADD 1+1, XOR 7^7) → grants alternate 0,1,0,1. The first response after reset is id 0. The XOR response has `rsp_zero=1`.
- **Backpressure.** `rsp_ready=0` for 5 cycles after `rsp_valid` while req1 is valid → `rsp_*` stay stable and `req_ready=0` throughout. When `rsp_ready` rises, req1 is granted in the same cycle.
- **Illegal opcode.** `op=4'b1010`, `a=b=0xFFFF_FFFF` → `rsp_result=0`, `rsp_zero=1`, `rsp_err=1`.
- **Reset mid-operation.** Assert `rst_n=0` during EXEC → all outputs are 0 immediately and no response appears. After release, pending requests from req0 and req1 are granted starting with req0.
- **Streaming throughput.** 8 back-to-back SLL requests (`a=1`, `b=i`) with `rsp_ready` held high → 8 responses `1<<i`, one every 2 cycles, in order.
